// File: rtl/alu16_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu16_seq_pkg
// Shared definitions for the 16-bit byte-serial ALU sequencer:
//   - req_op command encoding
//   - sequencer FSM state encoding
//   - 5-bit operation codes understood by the external 8-bit ALU
//   - helpers mapping a command onto the ALU codes for each byte pass
// Configuration macro: ALU16_SEQ_MUL_EN
//   defined   -> command 5 is a legal 8x8->16 multiply
//   undefined -> command 5 is handled as an illegal command
// -----------------------------------------------------------------------------
package alu16_seq_pkg;

  // Command encoding on req_op (6 and 7 are illegal)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // External 8-bit ALU operation codes
  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd9;   // a + b
  localparam logic [4:0] ALU_ADC  = 5'd10;  // a + b + 1
  localparam logic [4:0] ALU_SUB  = 5'd11;  // a - b, carry = borrow
  localparam logic [4:0] ALU_SBB  = 5'd14;  // a - b - 1, carry = borrow
  localparam logic [4:0] ALU_MULL = 5'd16;  // low byte of a * b
  localparam logic [4:0] ALU_MULH = 5'd17;  // high byte of a * b
  localparam logic [4:0] ALU_AND  = 5'd25;
  localparam logic [4:0] ALU_OR   = 5'd26;
  localparam logic [4:0] ALU_XOR  = 5'd27;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
`ifdef ALU16_SEQ_MUL_EN
      OP_MUL:                                return 1'b1;
`else
      OP_MUL:                                return 1'b0;
`endif
      default:                               return 1'b0;
    endcase
  endfunction

  // ALU code for the low-byte pass
  function automatic logic [4:0] low_alu_op(input logic [2:0] op);
    if (!op_legal(op)) return ALU_NOP;
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_MUL:  return ALU_MULL;
      default: return ALU_NOP;
    endcase
  endfunction

  // ALU code for the high-byte pass; lo_carry is the carry/borrow of the low pass
  function automatic logic [4:0] high_alu_op(input logic [2:0] op, input logic lo_carry);
    if (!op_legal(op)) return ALU_NOP;
    case (op)
      OP_ADD:  return lo_carry ? ALU_ADC : ALU_ADD;
      OP_SUB:  return lo_carry ? ALU_SBB : ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_MUL:  return ALU_MULH;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// -----------------------------------------------------------------------------
// alu16_seq
// Performs 16-bit ADD/SUB/AND/OR/XOR (and optional 8x8 MUL) by running two
// byte passes through an external combinational 8-bit ALU.
// Sequence: IDLE (accept) -> LOW -> HIGH -> DONE (response held until taken).
// Configuration macro: ALU16_SEQ_MUL_EN (enables command 5 = MUL).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        command handshake; req_op, req_a, req_b
//   alu_a, alu_b, alu_op       operand bytes / op code to the external ALU
//   alu_result, alu_carry      combinational ALU outputs, sampled same cycle
//   resp_valid/resp_ready      response handshake
//   resp_result, resp_carry, resp_zero, resp_neg, resp_err   response payload
// -----------------------------------------------------------------------------
module alu16_seq
  import alu16_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_result,
  output logic        resp_carry,
  output logic        resp_zero,
  output logic        resp_neg,
  output logic        resp_err
);

  state_e      state_q;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [15:0] result_q;
  logic        carry_q;
  logic        req_ready_q, resp_valid_q;
  logic        resp_carry_q, resp_zero_q, resp_neg_q, resp_err_q;
  logic [7:0]  alu_a_q, alu_b_q;
  logic [4:0]  alu_op_q;

  // Full result as it becomes known during the HIGH pass
  logic [15:0] full_result;
  assign full_result = {alu_result, result_q[7:0]};

  // The ALU drive registers are loaded one edge ahead of the pass that uses
  // them, so the ALU sees stable inputs for the whole LOW/HIGH cycle. The HIGH
  // op code depends on the low-pass carry, which is valid during LOW.
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values; blocking would make outcomes depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_carry_q <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_neg_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= ALU_NOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_LOW;
            req_ready_q <= 1'b0;
            op_q        <= req_op;
            a_q         <= req_a;
            b_q         <= req_b;
            alu_a_q     <= req_a[7:0];
            alu_b_q     <= req_b[7:0];
            alu_op_q    <= low_alu_op(req_op);
          end
        end
        ST_LOW: begin
          state_q       <= ST_HIGH;
          result_q[7:0] <= alu_result;
          carry_q       <= alu_carry;
          // MUL multiplies the low bytes; the high pass fetches the upper product byte
          alu_a_q       <= (op_q == OP_MUL) ? a_q[7:0] : a_q[15:8];
          alu_b_q       <= (op_q == OP_MUL) ? b_q[7:0] : b_q[15:8];
          alu_op_q      <= high_alu_op(op_q, alu_carry);
        end
        ST_HIGH: begin
          state_q        <= ST_DONE;
          result_q[15:8] <= alu_result;
          resp_valid_q   <= 1'b1;
          resp_carry_q   <= op_legal(op_q) && ((op_q == OP_ADD) || (op_q == OP_SUB))
                            ? alu_carry : 1'b0;
          resp_zero_q    <= (full_result == 16'h0000);
          resp_neg_q     <= full_result[15];
          resp_err_q     <= !op_legal(op_q);
          alu_a_q        <= '0;
          alu_b_q        <= '0;
          alu_op_q       <= ALU_NOP;
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_carry  = resp_carry_q;
  assign resp_zero   = resp_zero_q;
  assign resp_neg    = resp_neg_q;
  assign resp_err    = resp_err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_alu16_seq.sv
// -----------------------------------------------------------------------------
// tb_alu16_seq
// Bench for alu16_seq. Contains a behavioural model of the team's 32-op 8-bit
// ALU wired to the alu_* ports. Expected results follow ALU16_SEQ_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu16_seq;
  import alu16_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [4:0]  alu_op;
  logic        alu_carry;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_result;
  logic        resp_carry, resp_zero, resp_neg, resp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu16_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_carry(resp_carry),
    .resp_zero(resp_zero), .resp_neg(resp_neg), .resp_err(resp_err)
  );

  // 8-bit ALU model (codes used by the sequencer; everything else gives 0)
  logic [8:0]  sum9;
  logic [15:0] prod;
  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    sum9       = 9'h000;
    prod       = {8'h00, alu_a} * {8'h00, alu_b};
    case (alu_op)
      5'd9:  sum9 = {1'b0, alu_a} + {1'b0, alu_b};
      5'd10: sum9 = {1'b0, alu_a} + {1'b0, alu_b} + 9'd1;
      5'd11: sum9 = {1'b0, alu_a} - {1'b0, alu_b};
      5'd14: sum9 = {1'b0, alu_a} - {1'b0, alu_b} - 9'd1;
      5'd16: sum9 = {1'b0, prod[7:0]};
      5'd17: sum9 = {1'b0, prod[15:8]};
      5'd25: sum9 = {1'b0, alu_a & alu_b};
      5'd26: sum9 = {1'b0, alu_a | alu_b};
      5'd27: sum9 = {1'b0, alu_a ^ alu_b};
      default: sum9 = 9'h000;
    endcase
    alu_result = sum9[7:0];
    alu_carry  = sum9[8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        c, z, n, e;
    logic [4:0]  hop;
  } vec_t;

  vec_t vecs[14];

  // Full command: accept, LOW, HIGH, DONE, handshake; latency checked on the way
  task automatic run_cmd(input string tag, input vec_t v);
    @(negedge clk);
    check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    @(negedge clk);                      // LOW
    req_valid = 1'b0;
    check({tag, " low_ready"}, 32'(req_ready), 32'd0);
    check({tag, " low_valid"}, 32'(resp_valid), 32'd0);
    @(negedge clk);                      // HIGH
    check({tag, " high_op"}, 32'(alu_op), 32'(v.hop));
    check({tag, " high_valid"}, 32'(resp_valid), 32'd0);
    @(negedge clk);                      // DONE
    check({tag, " valid"}, 32'(resp_valid), 32'd1);
    check({tag, " result"}, 32'(resp_result), 32'(v.res));
    check({tag, " flags cznе"}, {28'd0, resp_carry, resp_zero, resp_neg, resp_err},
          {28'd0, v.c, v.z, v.n, v.e});
    check({tag, " done_aluop"}, 32'(alu_op), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " back_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;

    //            op      a         b         res       c     z     n     e     hop
    vecs[0]  = '{OP_ADD, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10};
    vecs[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10};
    vecs[2]  = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd14};
    vecs[3]  = '{OP_SUB, 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11};
    vecs[4]  = '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd25};
    vecs[5]  = '{OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 5'd26};
    vecs[6]  = '{OP_XOR, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 5'd27};
    vecs[7]  = '{OP_XOR, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd27};
`ifdef ALU16_SEQ_MUL_EN
    vecs[8]  = '{OP_MUL, 16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 1'b0, 1'b1, 1'b0, 5'd17};
    vecs[9]  = '{OP_MUL, 16'h1203, 16'h3404, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd17};
`else
    vecs[8]  = '{OP_MUL, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vecs[9]  = '{OP_MUL, 16'h1203, 16'h3404, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
`endif
    vecs[10] = '{3'd7,   16'hA5A5, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vecs[11] = '{3'd6,   16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vecs[12] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9};
    vecs[13] = '{OP_AND, 16'hFFFF, 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0, 5'd25};

    // Reset state
    #1;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst outputs", {resp_valid, resp_result, resp_carry, resp_zero, resp_neg, resp_err,
                          alu_a, alu_b, alu_op}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: response held, new requests ignored while busy
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_a = 16'h0003; req_b = 16'h0004;
    @(negedge clk);                      // LOW: offer a different command
    req_op = OP_XOR; req_a = 16'hFFFF; req_b = 16'h00F0;
    @(negedge clk);                      // HIGH
    @(negedge clk);                      // DONE
    check("bp valid", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d", k),
            {resp_valid, req_ready, resp_result, resp_carry, resp_zero, resp_neg, resp_err},
            {1'b1, 1'b0, 16'h0007, 4'b0000} );
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp release", {30'd0, resp_valid, req_ready}, 32'd1);

    // Reset during HIGH aborts the command
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_a = 16'h1234; req_b = 16'h1111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);                      // HIGH
    check("abort high_op", 32'(alu_op), 32'd9);
    #1 reset = 1'b1;
    #1;
    check("abort ready", 32'(req_ready), 32'd1);
    check("abort outputs", {resp_valid, resp_result, resp_carry, resp_zero, resp_neg, resp_err,
                            alu_a, alu_b, alu_op}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort no_resp%0d", k), {30'd0, resp_valid, req_ready}, 32'd1);
    end
    run_cmd("post_rst", '{OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  1  command offered; req_ready  output  1  sequencer can accept.
REQ-004 req_op  input  3  command: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6-7 illegal.
REQ-005 req_a, req_b  input  16  operands.
REQ-006 alu_a, alu_b  output  8  operand bytes to external 8-bit ALU; alu_op  output  5  ALU operation code.
REQ-007 alu_result  input  8; alu_carry  input  1  combinational ALU outputs, sampled same cycle as driven.
REQ-008 resp_valid  output  1; resp_ready  input  1  response handshake.
REQ-009 resp_result  output  16; resp_carry, resp_zero, resp_neg, resp_err  output  1 each.

Function
REQ-010 The FSM SHALL have states IDLE, LOW, HIGH, DONE; req_ready SHALL be 1 only in IDLE.
REQ-011 IDLE->LOW on req_valid&&req_ready; op and operands SHALL be registered at that edge.
REQ-012 LOW SHALL drive low bytes (MUL: req_a[7:0], req_b[7:0]) and capture alu_result into result[7:0] and alu_carry into a carry register; LOW->HIGH unconditionally.
REQ-013 HIGH SHALL drive high bytes (MUL: low bytes again) and capture alu_result into result[15:8]; HIGH->DONE unconditionally.
REQ-014 resp_valid SHALL be 1 only in DONE; DONE->IDLE on resp_ready; outputs SHALL stay stable while resp_ready=0.
REQ-015 Latency: resp_valid SHALL assert in the 3rd cycle after the accept edge (accept, LOW, HIGH, DONE); throughput one command per 4 cycles minimum.
REQ-016 ALU op map: ADD LOW 9, HIGH 10 if low carry else 9; SUB LOW 11, HIGH 14 if low borrow else 11; AND 25/25; OR 26/26; XOR 27/27; MUL LOW 16, HIGH 17.
REQ-017 resp_carry SHALL be alu_carry sampled in HIGH for ADD/SUB (carry out / borrow), 0 for all other ops.
REQ-018 resp_zero SHALL be 1 iff result[15:0]==0; resp_neg SHALL equal result[15]; ALU zero/negative outputs SHALL NOT be used.
REQ-019 Illegal op SHALL still traverse LOW/HIGH with alu_op=0, giving result 0, resp_err=1, resp_carry=0, resp_zero=1.
REQ-020 In IDLE and DONE the sequencer SHALL drive alu_op=0, alu_a=0, alu_b=0.
REQ-021 req_valid while not in IDLE SHALL be ignored (no accept, no state corruption).

Reset
REQ-022 Reset SHALL force IDLE, req_ready=1, resp_valid=0, resp_result=0, all resp flags 0, carry register 0, registered op/operands 0, ALU outputs 0.
REQ-023 Reset asserted mid-command SHALL abort it with no response produced; first command after deassertion SHALL complete normally.

Configuration
REQ-024 Macro ALU16_SEQ_MUL_EN: defined -> op 5 performs MUL per REQ-016; undefined -> op 5 SHALL be treated as illegal per REQ-019.

Structure
REQ-025 Shared package alu16_seq_pkg SHALL hold the req_op encoding, FSM state encoding, and named 5-bit ALU op constants (0, 9, 10, 11, 14, 16, 17, 25, 26, 27).
REQ-026 No sub-module; the 8-bit ALU is instantiated by the parent and wired to alu_* ports; the bench SHALL connect the team's 32-op ALU.

Verification
REQ-027 ADD 0x12FF+0x0001 -> 0x1300, HIGH alu_op=10, carry 0, zero 0, neg 0.
REQ-028 ADD 0xFFFF+0x0001 -> 0x0000, carry 1, zero 1; SUB 0x0000-0x0001 -> 0xFFFF, HIGH alu_op=14, carry 1, neg 1.
REQ-029 MUL 0x00FF*0x00FF -> 0xFE01 (MUL_EN defined); same stimulus, MUL_EN undefined -> 0x0000, err 1.
REQ-030 XOR 0xA5A5^0xFFFF -> 0x5A5A; req_op=7 -> 0x0000, err 1, zero 1.
REQ-031 Hold resp_ready=0 for 5 cycles after resp_valid -> result/flags stable, req_ready=0, new req_valid ignored; resp_ready=1 -> IDLE next edge.
REQ-032 Assert reset during HIGH -> all outputs per REQ-022 immediately; no resp_valid; next ADD 0x0001+0x0001 -> 0x0002 with latency per REQ-015.
